// File: rtl/fifo_ctrl_dp_if.sv
`default_nettype none
// ============================================================================
// fifo_ctrl_dp_if
//   Client push/pop bundle plus RAM port bundle for fifo_ctrl_dp.
//   Optional almost flags follow the macro FIFO_ALMOST_EN.
//   Revision: 1.0
// ============================================================================
interface fifo_ctrl_dp_if #(
  parameter int WIDTH   = 8,
  parameter int ADDRESS = 4
);
  logic               push;
  logic [WIDTH-1:0]   push_data;
  logic               pop;
  logic [WIDTH-1:0]   pop_data;
  logic               pop_valid;
  logic               full;
  logic               empty;
  logic [ADDRESS:0]   count;
  logic               overflow;
  logic               underflow;
  logic               ram_wr_en;
  logic [ADDRESS-1:0] ram_wr_addr;
  logic [WIDTH-1:0]   ram_wr_data;
  logic               ram_rd_en;
  logic [ADDRESS-1:0] ram_rd_addr;
  logic [WIDTH-1:0]   ram_rd_data;
`ifdef FIFO_ALMOST_EN
  logic               almost_full;
  logic               almost_empty;
`endif

  // The controller side; the master side is the client together with the RAM.
  modport slave (
    input  push, push_data, pop, ram_rd_data,
    output pop_data, pop_valid, full, empty, count, overflow, underflow,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_ALMOST_EN
    , output almost_full, almost_empty
`endif
  );

  modport master (
    output push, push_data, pop, ram_rd_data,
    input  pop_data, pop_valid, full, empty, count, overflow, underflow,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_ALMOST_EN
    , input almost_full, almost_empty
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl_dp.sv
`default_nettype none
// ============================================================================
// fifo_ctrl_dp
//   Synchronous FIFO controller driving a dual-port RAM with 1-cycle reads.
//   Optional almost_full/almost_empty flags with macro FIFO_ALMOST_EN.
//   Revision: 1.0
// ============================================================================
module fifo_ctrl_dp #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDRESS = 4
`ifdef FIFO_ALMOST_EN
  , parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
`endif
) (
  input  wire logic        clock,
  input  wire logic        reset,
  fifo_ctrl_dp_if.slave    bus
);
  localparam logic [ADDRESS:0] c_depth = DEPTH[ADDRESS:0];

  logic [ADDRESS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               pop_valid_q, pop_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               w_push_acc;
  logic               w_pop_acc;
  logic [WIDTH-1:0]   w_push_data;

  assign w_push_data = bus.push_data;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop_acc  = bus.pop & ~empty_q;
  assign w_push_acc = bus.push & (~full_q | w_pop_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (w_push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push_acc && !w_pop_acc)      count_d = count_q + 1'b1;
    else if (w_pop_acc && !w_push_acc) count_d = count_q - 1'b1;
    full_d      = (count_d == c_depth);
    empty_d     = (count_d == '0);
    pop_valid_d = w_pop_acc;
    overflow_d  = bus.push & full_q & ~w_pop_acc;
    underflow_d = bus.pop & empty_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.ram_wr_en   = w_push_acc;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_wr_data = w_push_data;
  assign bus.ram_rd_en   = w_pop_acc;
  assign bus.ram_rd_addr = rd_ptr_q;

  assign bus.pop_data  = bus.ram_rd_data;
  assign bus.pop_valid = pop_valid_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef FIFO_ALMOST_EN
  localparam logic [ADDRESS:0] c_af_level = AF_LEVEL[ADDRESS:0];
  localparam logic [ADDRESS:0] c_ae_level = AE_LEVEL[ADDRESS:0];

  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;

  always_comb begin
    almost_full_d  = (count_d >= c_af_level);
    almost_empty_d = (count_d <= c_ae_level);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_dp.sv
`default_nettype none
// ============================================================================
// tb_fifo_ctrl_dp
//   Directed self-checking bench for fifo_ctrl_dp with a behavioural RAM.
//   Revision: 1.0
// ============================================================================
module tb_fifo_ctrl_dp;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fifo_ctrl_dp_if #(.WIDTH(8), .ADDRESS(4)) bus ();

  fifo_ctrl_dp #(.WIDTH(8), .DEPTH(16), .ADDRESS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Dual-port RAM: registered read, old data on a same-address write.
  logic [7:0] mem [16];
  always @(posedge clock) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  task automatic drive(input logic p, input logic [7:0] d, input logic q);
    @(negedge clock);
    bus.push = p; bus.push_data = d; bus.pop = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.push = 0; bus.pop = 0; bus.push_data = '0; bus.ram_rd_data = '0;
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: count=%0d empty=%b full=%b, want 0/1/0", bus.count, bus.empty, bus.full);
    end
    checks++;
    if (bus.pop_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: pv=%b ov=%b un=%b, want 0/0/0", bus.pop_valid, bus.overflow, bus.underflow);
    end
`ifdef FIFO_ALMOST_EN
    checks++;
    if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin
      errors++; $display("FAIL reset_almost: af=%b ae=%b, want 0/1", bus.almost_full, bus.almost_empty);
    end
`endif
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 | 8'((i + 1) % 16);
      drive(1, d, 0);
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 4'(i) || bus.ram_wr_data !== d) begin
        errors++; $display("FAIL fill_ram[%0d]: en=%b addr=%0d data=%h, want 1/%0d/%h", i, bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data, i, d);
      end
      tick();
      checks++;
      if (bus.count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: count=%0d, want %0d", i, bus.count, i + 1);
      end
`ifdef FIFO_ALMOST_EN
      checks++;
      if (bus.almost_full !== (i + 1 >= 12) || bus.almost_empty !== (i + 1 <= 4)) begin
        errors++; $display("FAIL fill_almost[%0d]: af=%b ae=%b, want %b/%b", i, bus.almost_full, bus.almost_empty, (i + 1 >= 12), (i + 1 <= 4));
      end
`endif
    end
    checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b empty=%b, want 1/0", bus.full, bus.empty);
    end
    drive(1, 8'hEE, 0);
    checks++;
    if (bus.ram_wr_en !== 1'b0) begin
      errors++; $display("FAIL overflow_wr_en: ram_wr_en=%b, want 0", bus.ram_wr_en);
    end
    tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      errors++; $display("FAIL overflow_pulse: ov=%b count=%0d, want 1/16", bus.overflow, bus.count);
    end
    drive(0, 8'h00, 0);
    tick();
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: ov=%b, want 0", bus.overflow);
    end
  endtask

  task automatic test_drain_underflow();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 | 8'((i + 1) % 16);
      drive(0, 8'h00, 1);
      checks++;
      if (bus.ram_rd_en !== 1'b1 || bus.ram_rd_addr !== 4'(i)) begin
        errors++; $display("FAIL drain_ram[%0d]: en=%b addr=%0d, want 1/%0d", i, bus.ram_rd_en, bus.ram_rd_addr, i);
      end
      tick();
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== d) begin
        errors++; $display("FAIL drain_data[%0d]: pv=%b data=%h, want 1/%h", i, bus.pop_valid, bus.pop_data, d);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.full !== 1'b0) begin
      errors++; $display("FAIL drain_empty: empty=%b count=%0d full=%b, want 1/0/0", bus.empty, bus.count, bus.full);
    end
    drive(0, 8'h00, 1);
    checks++;
    if (bus.ram_rd_en !== 1'b0) begin
      errors++; $display("FAIL underflow_rd_en: ram_rd_en=%b, want 0", bus.ram_rd_en);
    end
    tick();
    checks++;
    if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0 || bus.count !== 5'd0) begin
      errors++; $display("FAIL underflow_pulse: un=%b pv=%b count=%0d, want 1/0/0", bus.underflow, bus.pop_valid, bus.count);
    end
    drive(0, 8'h00, 0);
    tick();
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++; $display("FAIL underflow_clear: un=%b, want 0", bus.underflow);
    end
  endtask

  // Pointers start at 0 here; 10 + 10 pushes carry wr_ptr through 15 -> 0.
  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin drive(1, 8'(8'h30 + i), 0); tick(); end
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h00, 1); tick();
      checks++;
      if (bus.pop_data !== 8'(8'h30 + i)) begin
        errors++; $display("FAIL wrap_pop1[%0d]: data=%h, want %h", i, bus.pop_data, 8'(8'h30 + i));
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h40 + i), 0);
      checks++;
      if (bus.ram_wr_addr !== 4'((10 + i) % 16)) begin
        errors++; $display("FAIL wrap_wr_addr[%0d]: addr=%0d, want %0d", i, bus.ram_wr_addr, (10 + i) % 16);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h00, 1);
      checks++;
      if (bus.ram_rd_addr !== 4'((10 + i) % 16)) begin
        errors++; $display("FAIL wrap_rd_addr[%0d]: addr=%0d, want %0d", i, bus.ram_rd_addr, (10 + i) % 16);
      end
      tick();
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL wrap_pop2[%0d]: pv=%b data=%h, want 1/%h", i, bus.pop_valid, bus.pop_data, 8'(8'h40 + i));
      end
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) begin drive(1, 8'(8'h20 + i), 0); tick(); end
    drive(1, 8'hAA, 1);
    tick();
    checks++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      errors++; $display("FAIL full_pp_state: count=%0d ov=%b full=%b, want 16/0/1", bus.count, bus.overflow, bus.full);
    end
    checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h20) begin
      errors++; $display("FAIL full_pp_data: pv=%b data=%h, want 1/20", bus.pop_valid, bus.pop_data);
    end
    for (int i = 1; i < 17; i++) begin
      drive(0, 8'h00, 1); tick();
      checks++;
      if (bus.pop_data !== ((i == 16) ? 8'hAA : 8'(8'h20 + i))) begin
        errors++; $display("FAIL full_pp_drain[%0d]: data=%h, want %h", i, bus.pop_data, (i == 16) ? 8'hAA : 8'(8'h20 + i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++; $display("FAIL full_pp_empty: empty=%b count=%0d, want 1/0", bus.empty, bus.count);
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic test_empty_push_pop();
    drive(1, 8'h55, 1);
    tick();
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || bus.pop_valid !== 1'b0 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL empty_pp_state: un=%b count=%0d pv=%b empty=%b, want 1/1/0/0", bus.underflow, bus.count, bus.pop_valid, bus.empty);
    end
    drive(0, 8'h00, 1);
    tick();
    checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h55 || bus.count !== 5'd0) begin
      errors++; $display("FAIL empty_pp_pop: pv=%b data=%h count=%0d, want 1/55/0", bus.pop_valid, bus.pop_data, bus.count);
    end
    drive(0, 8'h00, 0);
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin drive(1, 8'(8'h60 + i), 0); tick(); end
    drive(1, 8'h67, 1);
    tick();
    checks++;
    if (bus.count !== 5'd7 || bus.pop_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre: count=%0d pv=%b, want 7/1", bus.count, bus.pop_valid);
    end
    // Reset lands mid-cycle, well clear of any clock edge.
    #1 reset = 0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.pop_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: count=%0d empty=%b full=%b pv=%b, want 0/1/0/0", bus.count, bus.empty, bus.full, bus.pop_valid);
    end
    checks++;
    if (bus.ram_rd_en !== 1'b0 || bus.ram_wr_addr !== 4'd0 || bus.ram_rd_addr !== 4'd0) begin
      errors++; $display("FAIL mid_reset_ram: rd_en=%b wa=%0d ra=%0d, want 0/0/0", bus.ram_rd_en, bus.ram_wr_addr, bus.ram_rd_addr);
    end
`ifdef FIFO_ALMOST_EN
    checks++;
    if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin
      errors++; $display("FAIL mid_reset_almost: af=%b ae=%b, want 0/1", bus.almost_full, bus.almost_empty);
    end
`endif
    drive(0, 8'h00, 0);
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_full_push_pop();
    test_empty_push_pop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
